// File: rtl/i2c_slave_word.sv
// I2C target that receives or returns one DATA_W-bit word packed MSB-first into bytes.
// Optional macro I2C_GENCALL_EN also ACKs general-call (7'h00) writes.
module i2c_slave_word #(
  parameter logic [6:0]  SLAVE_ADDR = 7'd52,
  parameter int unsigned DATA_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  inout  wire               sda,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_ack,
  output logic              busy
);

  localparam int unsigned NBYTES = (DATA_W + 7) / 8;
  localparam int unsigned SW     = NBYTES * 8;
  localparam int unsigned PAD    = SW - DATA_W;
  localparam int unsigned IDX_W  = $clog2(NBYTES + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  state_t             state, state_n;
  logic [3:0]         cnt, cnt_n;
  logic [7:0]         sh, sh_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [SW-1:0]      stage, stage_n;
  logic [SW-1:0]      rd_sh, rd_sh_n;
  logic               wr_mode, wr_mode_n;
  logic               busy_n, oe, oe_n;
  logic [DATA_W-1:0]  rx_data_n;
  logic               rx_valid_n, tx_ack_n;

  logic scl_q1, scl_q2, scl_q3, sda_q1, sda_q2, sda_q3;
  logic scl_rise, scl_fall, start_det, stop_det, addr_hit;
  logic [7:0] bit_in;

  assign sda = oe ? 1'b0 : 1'bz;

  // Two-flop synchronisers plus one history stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_q1, scl_q2, scl_q3} <= 3'b111;
      {sda_q1, sda_q2, sda_q3} <= 3'b111;
    end else begin
      {scl_q1, scl_q2, scl_q3} <= {scl, scl_q1, scl_q2};
      {sda_q1, sda_q2, sda_q3} <= {sda, sda_q1, sda_q2};
    end
  end

  assign scl_rise  = scl_q2 & ~scl_q3;
  assign scl_fall  = ~scl_q2 & scl_q3;
  assign start_det = scl_q2 & scl_q3 & sda_q3 & ~sda_q2;
  assign stop_det  = scl_q2 & scl_q3 & ~sda_q3 & sda_q2;
  assign bit_in    = {sh[6:0], sda_q2};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      idx      <= '0;
      stage    <= '0;
      rd_sh    <= '0;
      wr_mode  <= 1'b0;
      busy     <= 1'b0;
      oe       <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ack   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sh       <= sh_n;
      idx      <= idx_n;
      stage    <= stage_n;
      rd_sh    <= rd_sh_n;
      wr_mode  <= wr_mode_n;
      busy     <= busy_n;
      oe       <= oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_ack   <= tx_ack_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sh_n       = sh;
    idx_n      = idx;
    stage_n    = stage;
    rd_sh_n    = rd_sh;
    wr_mode_n  = wr_mode;
    busy_n     = busy;
    oe_n       = oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_ack_n   = 1'b0;

    addr_hit = (bit_in[7:1] == SLAVE_ADDR);
`ifdef I2C_GENCALL_EN
    addr_hit = addr_hit | (bit_in == 8'h00);
`endif

    if (stop_det) begin
      if (wr_mode && (idx == IDX_W'(NBYTES))) begin
        rx_data_n  = stage[SW-1 -: DATA_W];
        rx_valid_n = 1'b1;
      end
      state_n   = IDLE;
      busy_n    = 1'b0;
      oe_n      = 1'b0;
      wr_mode_n = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      cnt_n     = '0;
      idx_n     = '0;
      busy_n    = 1'b0;
      oe_n      = 1'b0;
      wr_mode_n = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          sh_n  = bit_in;
          cnt_n = 4'(cnt + 4'd1);
          if (cnt == 4'd7) begin
            cnt_n = '0;
            if (addr_hit) begin
              state_n = ADDR_ACK;
              busy_n  = 1'b1;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        // cnt marks whether the 9th rise has been seen; sh[0] holds R/W
        ADDR_ACK: if (scl_rise) begin
          cnt_n = 4'd1;
          if (sh[0]) begin
            rd_sh_n  = SW'(tx_data) << PAD;
            tx_ack_n = 1'b1;
          end
        end else if (scl_fall) begin
          if (cnt == 4'd0) begin
            oe_n = 1'b1;
          end else begin
            cnt_n = '0;
            if (sh[0]) begin
              state_n = RD_BYTE;
              oe_n    = ~rd_sh[SW-1];
              rd_sh_n = {rd_sh[SW-2:0], 1'b1};
            end else begin
              state_n   = WR_BYTE;
              oe_n      = 1'b0;
              wr_mode_n = 1'b1;
              idx_n     = '0;
            end
          end
        end
        WR_BYTE: if (scl_rise) begin
          sh_n  = bit_in;
          cnt_n = 4'(cnt + 4'd1);
          if (cnt == 4'd7) begin
            cnt_n = '0;
            if (idx < IDX_W'(NBYTES)) begin
              stage_n = (stage << 8) | SW'(bit_in);
              idx_n   = IDX_W'(idx + 1'b1);
              state_n = WR_ACK;
            end else begin
              state_n = WAIT_STOP;
              busy_n  = 1'b0;
            end
          end
        end
        WR_ACK: if (scl_rise) begin
          cnt_n = 4'd1;
        end else if (scl_fall) begin
          if (cnt == 4'd0) begin
            oe_n = 1'b1;
          end else begin
            cnt_n   = '0;
            oe_n    = 1'b0;
            state_n = WR_BYTE;
          end
        end
        // First bit is already on the bus at entry; ones shift in so bytes past the word read FF
        RD_BYTE: if (scl_rise) begin
          cnt_n = 4'(cnt + 4'd1);
        end else if (scl_fall) begin
          if (cnt == 4'd8) begin
            cnt_n   = '0;
            oe_n    = 1'b0;
            state_n = RD_ACK;
          end else begin
            oe_n    = ~rd_sh[SW-1];
            rd_sh_n = {rd_sh[SW-2:0], 1'b1};
          end
        end
        RD_ACK: if (scl_rise) begin
          if (sda_q2) begin
            state_n = WAIT_STOP;
            busy_n  = 1'b0;
          end else begin
            cnt_n = 4'd1;
          end
        end else if (scl_fall && (cnt == 4'd1)) begin
          cnt_n   = '0;
          state_n = RD_BYTE;
          oe_n    = ~rd_sh[SW-1];
          rd_sh_n = {rd_sh[SW-2:0], 1'b1};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_word.sv
// Self-checking bench for i2c_slave_word: directed and randomized I2C transactions
// compared against a byte-level model of the word packing and ACK rules.
module tb_i2c_slave_word;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned NB     = (DATA_W + 7) / 8;
  localparam int unsigned SW     = NB * 8;
  localparam logic [6:0]  SLAVE  = 7'd52;
  localparam int          Q      = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              scl = 1'b1;
  logic              m_oe = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, tx_ack, busy;
  wire               sda_bus;

  int n_cmp = 0;
  int n_err = 0;
  int rxv_cnt = 0;
  int txa_cnt = 0;
  int busy_cyc = 0;
  logic [DATA_W-1:0] model_rx = '0;

  always #5 clk = ~clk;

  assign sda_bus = m_oe ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave_word #(.SLAVE_ADDR(SLAVE), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda_bus),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_ack(tx_ack), .busy(busy)
  );

  always @(posedge clk) begin
    if (rx_valid) rxv_cnt <= rxv_cnt + 1;
    if (tx_ack)   txa_cnt <= txa_cnt + 1;
    if (busy)     busy_cyc <= busy_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic qwait;
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start;
    m_oe = 1'b0; qwait; scl = 1'b1; qwait; m_oe = 1'b1; qwait; scl = 1'b0; qwait;
  endtask

  task automatic i2c_stop;
    m_oe = 1'b1; qwait; scl = 1'b1; qwait; m_oe = 1'b0; qwait;
  endtask

  task automatic write_bit(input logic b);
    m_oe = ~b; qwait; scl = 1'b1; qwait; qwait; scl = 1'b0; qwait;
  endtask

  task automatic read_bit(output logic b);
    m_oe = 1'b0; qwait; scl = 1'b1; qwait; b = sda_bus; qwait; scl = 1'b0; qwait;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      read_bit(s);
      d[i] = s;
    end
    write_bit(~master_ack);
  endtask

  // Model: an address is claimed if it matches, or is a general-call write when enabled
  function automatic logic model_addr_ack(input logic [7:0] ab);
`ifdef I2C_GENCALL_EN
    if (ab == 8'h00) return 1'b1;
`endif
    return ab[7:1] == SLAVE;
  endfunction

  // Model: word is the top DATA_W bits of the first NB bytes concatenated
  function automatic logic [DATA_W-1:0] model_word(input logic [7:0] d[$]);
    logic [SW-1:0] cat;
    cat = '0;
    for (int k = 0; k < int'(NB); k++) cat = (cat << 8) | SW'(d[k]);
    return DATA_W'(cat >> (SW - DATA_W));
  endfunction

  // Model: k-th returned byte is the word left-justified with zero pad, then FF beyond
  function automatic logic [7:0] model_rd_byte(input logic [DATA_W-1:0] tx, input int k);
    logic [SW-1:0] full;
    if (k >= int'(NB)) return 8'hFF;
    full = SW'(tx) << (SW - DATA_W);
    return 8'(full >> (8 * (int'(NB) - 1 - k)));
  endfunction

  task automatic write_txn(input string tag, input logic [7:0] ab, input logic [7:0] d[$]);
    int rx0, b0;
    logic a, ea, commit;
    rx0 = rxv_cnt;
    b0  = busy_cyc;
    ea  = model_addr_ack(ab);
    i2c_start;
    write_byte(ab, a);
    check($sformatf("%s_addr_ack", tag), 32'(a), 32'(ea));
    if (ea) begin
      for (int k = 0; k < d.size(); k++) begin
        write_byte(d[k], a);
        check($sformatf("%s_data_ack%0d", tag, k), 32'(a), 32'(k < int'(NB)));
      end
    end
    i2c_stop;
    repeat (4) @(negedge clk);
    commit = ea && (d.size() >= int'(NB));
    if (commit) model_rx = model_word(d);
    check($sformatf("%s_rx_valid_pulses", tag), 32'(rxv_cnt - rx0), 32'(commit));
    check($sformatf("%s_rx_data", tag), 32'(rx_data), 32'(model_rx));
    check($sformatf("%s_busy_after", tag), 32'(busy), 32'd0);
    if (!ea) check($sformatf("%s_busy_never", tag), 32'(busy_cyc - b0), 32'd0);
  endtask

  task automatic read_txn(input string tag, input logic [7:0] ab,
                          input logic [DATA_W-1:0] tx, input int nrd);
    int t0;
    logic a, ea;
    logic [7:0] b;
    tx_data = tx;
    t0 = txa_cnt;
    ea = model_addr_ack(ab);
    i2c_start;
    write_byte(ab, a);
    check($sformatf("%s_addr_ack", tag), 32'(a), 32'(ea));
    check($sformatf("%s_tx_ack_pulses", tag), 32'(txa_cnt - t0), 32'(ea));
    check($sformatf("%s_busy", tag), 32'(busy), 32'(ea));
    if (ea) begin
      tx_data = ~tx;
      for (int k = 0; k < nrd; k++) begin
        read_byte(k < nrd - 1, b);
        check($sformatf("%s_byte%0d", tag, k), 32'(b), 32'(model_rd_byte(tx, k)));
      end
      check($sformatf("%s_busy_after_nack", tag), 32'(busy), 32'd0);
    end
    i2c_stop;
    repeat (4) @(negedge clk);
    check($sformatf("%s_busy_after_stop", tag), 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic a, s;
    int r0;
    logic [DATA_W-1:0] w;
    logic [SW-1:0] full;
    int nb;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_ack", 32'(tx_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sda", 32'(sda_bus), 32'd1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    q = '{8'hAB, 8'hC0};
    write_txn("t1", 8'h68, q);
    q = '{8'h11};
    write_txn("t2", 8'h6A, q);
    read_txn("t3", 8'h69, 12'h5A3, 2);

    q = '{8'hAB};
    write_txn("t4a", 8'h68, q);
    q = '{8'h12, 8'h34, 8'h56};
    write_txn("t4b", 8'h68, q);

    // Aborted write followed by a repeated START
    r0 = rxv_cnt;
    i2c_start;
    write_byte(8'h68, a);
    check("t5_addr_ack", 32'(a), 32'd1);
    for (int i = 7; i >= 4; i--) write_bit(1'b1);
    i2c_start;
    write_byte(8'h68, a);
    check("t5_addr2_ack", 32'(a), 32'd1);
    write_byte(8'hDE, a);
    check("t5_ack0", 32'(a), 32'd1);
    write_byte(8'hF0, a);
    check("t5_ack1", 32'(a), 32'd1);
    i2c_stop;
    repeat (4) @(negedge clk);
    model_rx = 12'hDEF;
    check("t5_rx_valid_pulses", 32'(rxv_cnt - r0), 32'd1);
    check("t5_rx_data", 32'(rx_data), 32'(model_rx));

    q = '{8'h12, 8'h30};
    write_txn("t6_gencall_wr", 8'h00, q);
    read_txn("t6_gencall_rd", 8'h01, 12'hFFF, 1);

    // Randomized writes with random pad bits and byte counts, and randomized reads
    for (int it = 0; it < 5; it++) begin
      w    = DATA_W'($urandom);
      full = (SW'(w) << (SW - DATA_W)) | SW'($urandom_range(0, (1 << (SW - DATA_W)) - 1));
      nb   = $urandom_range(1, 3);
      q.delete();
      for (int k = 0; k < nb; k++)
        q.push_back((k < int'(NB)) ? 8'(full >> (8 * (int'(NB) - 1 - k))) : 8'($urandom));
      write_txn($sformatf("rnd_wr%0d", it), 8'h68, q);
      read_txn($sformatf("rnd_rd%0d", it), 8'h69, DATA_W'($urandom), $urandom_range(1, 3));
    end

    // Reset while the slave is driving a zero data bit
    tx_data = '0;
    i2c_start;
    write_byte(8'h69, a);
    check("rst_rd_addr_ack", 32'(a), 32'd1);
    read_bit(s);
    read_bit(s);
    check("rst_rd_drive_low", 32'(sda_bus), 32'd0);
    r0 = rxv_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rd_sda_released", 32'(sda_bus), 32'd1);
    check("rst_rd_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    i2c_stop;
    repeat (4) @(negedge clk);
    model_rx = '0;
    check("rst_rd_no_pulse", 32'(rxv_cnt - r0), 32'd0);
    check("rst_rd_rx_data", 32'(rx_data), 32'(model_rx));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
